// File: rtl/gpr_wr_arbiter_pkg.sv
// Shared definitions for the GPR write path.
// Holds the register-file geometry (also used by the gpr module), the
// register-zero constant and the grant-source encoding of the arbiter.
package gpr_wr_arbiter_pkg;
  localparam int GPR_AW = 5;
  localparam int GPR_DW = 32;
  localparam logic [GPR_AW-1:0] GPR_ZERO = '0;

  // Which source drives the gpr write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_A,     // writeback stage
    GNT_HEAD,  // oldest queued MD result
    GNT_BYP    // MD result written straight through, FIFO empty
  } gnt_e;
endpackage

// File: rtl/gpr_wr_arbiter_if.sv
// Bus bundle between requesters / hazard unit / gpr and the write arbiter.
//   a_*      : writeback-stage write request (a_ready back)
//   b_*      : multiply/divide result (b_ready back)
//   q_rs/rt  : hazard-unit query addresses, pend_rs/rt answers
//   gpr_*    : the register file's single write port
// master = environment side, slave = arbiter side.
interface gpr_wr_arbiter_if
  import gpr_wr_arbiter_pkg::*;
#(
  parameter int AW = GPR_AW,
  parameter int DW = GPR_DW
);
  logic          a_valid, a_ready;
  logic [AW-1:0] a_rd;
  logic [DW-1:0] a_wd;
  logic          b_valid, b_ready;
  logic [AW-1:0] b_rd;
  logic [DW-1:0] b_wd;
  logic [AW-1:0] q_rs, q_rt;
  logic          pend_rs, pend_rt;
  logic          gpr_we;
  logic [AW-1:0] gpr_rd;
  logic [DW-1:0] gpr_wd;

  modport master (
    output a_valid, a_rd, a_wd, b_valid, b_rd, b_wd, q_rs, q_rt,
    input  a_ready, b_ready, pend_rs, pend_rt, gpr_we, gpr_rd, gpr_wd
  );
  modport slave (
    input  a_valid, a_rd, a_wd, b_valid, b_rd, b_wd, q_rs, q_rt,
    output a_ready, b_ready, pend_rs, pend_rt, gpr_we, gpr_rd, gpr_wd
  );
endinterface

// File: rtl/gpr_wr_arbiter_wr_fifo.sv
// wr_fifo: small synchronous FIFO of pending MD writes {rd, wd}.
// Ports: clk, rst (sync, active-low); push_i/wrd_i/wwd_i enqueue;
// pop_i dequeues; head_rd_o/head_wd_o oldest entry; count_o occupancy;
// vld_o/addr_o per-slot valid + destination for the scoreboard compare.
// Caller must never push when full nor pop when empty.
module wr_fifo
  import gpr_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = GPR_AW,
  parameter int DW    = GPR_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [AW-1:0]            wrd_i,
  input  logic [DW-1:0]            wwd_i,
  input  logic                     pop_i,
  output logic [AW-1:0]            head_rd_o,
  output logic [DW-1:0]            head_wd_o,
  output logic [CW-1:0]            count_o,
  output logic [DEPTH-1:0]         vld_o,
  output logic [DEPTH-1:0][AW-1:0] addr_o
);
  logic [DEPTH-1:0][AW-1:0] rd_q;
  logic [DEPTH-1:0][DW-1:0] wd_q;
  logic [DEPTH-1:0]         vld_q;
  logic [PW-1:0]            wptr_q, rptr_q;
  logic [CW-1:0]            cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      // push never targets the slot being popped (no push when full)
      if (push_i) begin
        vld_q[wptr_q] <= 1'b1;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_i) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // payload needs no reset: qualified by vld_q
  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_q[wptr_q] <= wrd_i;
      wd_q[wptr_q] <= wwd_i;
    end
  end

  assign head_rd_o = rd_q[rptr_q];
  assign head_wd_o = wd_q[rptr_q];
  assign count_o   = cnt_q;
  assign vld_o     = vld_q;
  assign addr_o    = rd_q;
endmodule

// File: rtl/gpr_wr_arbiter.sv
// gpr_wr_arbiter: shares the GPR write port between the writeback stage
// (A, priority, never buffered) and the MD unit (B, buffered in wr_fifo),
// with a starvation guard for queued B results and a pending-write
// scoreboard for the hazard unit.
// Ports: clk, rst (sync, active-low), bus (gpr_wr_arbiter_if.slave).
module gpr_wr_arbiter
  import gpr_wr_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = GPR_AW,
  parameter int DW           = GPR_DW
) (
  input  logic clk,
  input  logic rst,
  gpr_wr_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]            count;
  logic [DEPTH-1:0]         ent_vld;
  logic [DEPTH-1:0][AW-1:0] ent_rd;
  logic [AW-1:0]            head_rd;
  logic [DW-1:0]            head_wd;
  logic [SW-1:0]            starve_q, starve_d;
  logic fifo_empty, stall, b_rdy, eff_a, eff_b_acc, push, pop;
  logic hit_rs, hit_rt;
  gnt_e gnt;

  assign fifo_empty = (count == '0);
  assign stall      = (starve_q == SW'(STARVE_LIMIT));
  assign b_rdy      = rst & (count < CW'(DEPTH));
  assign eff_a      = bus.a_valid & (bus.a_rd != '0);
  // accepted B that actually needs a write (rd==0 is accepted and dropped)
  assign eff_b_acc  = bus.b_valid & b_rdy & (bus.b_rd != '0);

  always_comb begin
    gnt = GNT_NONE;
    if (!rst)               gnt = GNT_NONE;
    else if (stall)         gnt = fifo_empty ? GNT_NONE : GNT_HEAD;
    else if (eff_a)         gnt = GNT_A;
    else if (!fifo_empty)   gnt = GNT_HEAD;
    else if (eff_b_acc)     gnt = GNT_BYP;
  end

  assign pop  = (gnt == GNT_HEAD);
  assign push = eff_b_acc & (gnt != GNT_BYP);

  always_comb begin
    bus.gpr_we = 1'b0;
    bus.gpr_rd = '0;
    bus.gpr_wd = '0;
    case (gnt)
      GNT_A:    begin bus.gpr_we = 1'b1; bus.gpr_rd = bus.a_rd; bus.gpr_wd = bus.a_wd; end
      GNT_HEAD: begin bus.gpr_we = 1'b1; bus.gpr_rd = head_rd;  bus.gpr_wd = head_wd;  end
      GNT_BYP:  begin bus.gpr_we = 1'b1; bus.gpr_rd = bus.b_rd; bus.gpr_wd = bus.b_wd; end
      default:  ;
    endcase
  end

  assign bus.a_ready = ~stall | ~rst;
  assign bus.b_ready = b_rdy;

  // Counts A wins that overtake a waiting head; a pop or empty FIFO
  // means nobody is being starved.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty)                                 starve_d = '0;
    else if (gnt == GNT_A && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_rs = hit_rs | (ent_vld[i] & (ent_rd[i] == bus.q_rs));
      hit_rt = hit_rt | (ent_vld[i] & (ent_rd[i] == bus.q_rt));
    end
  end

  assign bus.pend_rs = rst & (bus.q_rs != '0) & hit_rs;
  assign bus.pend_rt = rst & (bus.q_rt != '0) & hit_rt;

  wr_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wrd_i     (bus.b_rd),
    .wwd_i     (bus.b_wd),
    .pop_i     (pop),
    .head_rd_o (head_rd),
    .head_wd_o (head_wd),
    .count_o   (count),
    .vld_o     (ent_vld),
    .addr_o    (ent_rd)
  );
endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Bench for gpr_wr_arbiter: directed scenarios with literal expectations
// followed by random traffic, all compared every cycle against a
// queue-based model of the arbitration rules.
module tb_gpr_wr_arbiter;
  localparam int DEPTH = 2;
  localparam int SL    = 4;

  logic clk, rst;
  gpr_wr_arbiter_if #(.AW(5), .DW(32)) bus ();

  gpr_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(SL), .AW(5), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  ent_t mq[$];
  int   mstarve;
  int   checks, errors;

  // expectations / decisions of the current cycle
  logic        e_we, e_ar, e_br, e_prs, e_prt;
  logic [4:0]  e_rd;
  logic [31:0] e_wd;
  logic        m_pop, m_push, m_awin, m_rst;
  ent_t        m_new;

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0b want=%0b", nm, $time, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic set_in(input logic av, input int ard, input int awd,
                        input logic bv, input int brd, input int bwd,
                        input int qrs, input int qrt);
    bus.a_valid = av;  bus.a_rd = 5'(ard); bus.a_wd = 32'(awd);
    bus.b_valid = bv;  bus.b_rd = 5'(brd); bus.b_wd = 32'(bwd);
    bus.q_rs = 5'(qrs); bus.q_rt = 5'(qrt);
  endtask

  function automatic logic queued(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  // model evaluation + per-cycle compare, mid-cycle
  task automatic eval_chk();
    logic stall, effa, effb, bacc;
    #2;
    m_rst = rst; m_pop = 0; m_push = 0; m_awin = 0;
    m_new.rd = bus.b_rd; m_new.wd = bus.b_wd;
    e_we = 0; e_rd = 0; e_wd = 0;
    if (!rst) begin
      e_ar = 1; e_br = 0; e_prs = 0; e_prt = 0;
    end else begin
      stall = (mstarve == SL);
      e_ar  = !stall;
      e_br  = (mq.size() < DEPTH);
      effa  = bus.a_valid && bus.a_rd != 0 && !stall;
      bacc  = bus.b_valid && e_br;
      effb  = bacc && bus.b_rd != 0;
      if (stall || (!effa && mq.size() > 0)) begin
        if (mq.size() > 0) begin
          e_we = 1; e_rd = mq[0].rd; e_wd = mq[0].wd; m_pop = 1;
        end
        m_push = effb;
      end else if (effa) begin
        e_we = 1; e_rd = bus.a_rd; e_wd = bus.a_wd; m_awin = 1;
        m_push = effb;
      end else if (effb) begin
        e_we = 1; e_rd = bus.b_rd; e_wd = bus.b_wd;  // bypass
      end
      e_prs = queued(bus.q_rs);
      e_prt = queued(bus.q_rt);
    end
    chkb("a_ready", bus.a_ready, e_ar);
    chkb("b_ready", bus.b_ready, e_br);
    chkb("gpr_we",  bus.gpr_we,  e_we);
    if (e_we || !rst) begin
      chkv("gpr_rd", 32'(bus.gpr_rd), 32'(e_rd));
      chkv("gpr_wd", bus.gpr_wd, e_wd);
    end
    chkb("pend_rs", bus.pend_rs, e_prs);
    chkb("pend_rt", bus.pend_rt, e_prt);
  endtask

  task automatic tick();
    logic was_empty;
    @(posedge clk);
    if (!m_rst) begin
      mq.delete();
      mstarve = 0;
    end else begin
      was_empty = (mq.size() == 0);
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(m_new);
      if (m_pop || was_empty)        mstarve = 0;
      else if (m_awin && mstarve < SL) mstarve++;
    end
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; mstarve = 0;
    // reset held 3 cycles with both requesters active
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 3, 'h11, 1, 7, 'h22, 7, 3);
      eval_chk();
      chkb("rst_we", bus.gpr_we, 1'b0);
      chkb("rst_brdy", bus.b_ready, 1'b0);
      chkb("rst_ardy", bus.a_ready, 1'b1);
      tick();
    end
    rst = 1;

    // bypass
    set_in(0, 0, 0, 1, 8, 'h1234, 8, 0);
    eval_chk();
    chkb("byp_we", bus.gpr_we, 1'b1);
    chkv("byp_rd", 32'(bus.gpr_rd), 32'd8);
    chkv("byp_wd", bus.gpr_wd, 32'h1234);
    chkb("byp_pend", bus.pend_rs, 1'b0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 8, 0); eval_chk(); tick();

    // queue + scoreboard
    set_in(1, 3, 'h33, 1, 9, 'hA, 9, 10); eval_chk();
    chkv("q1_rd", 32'(bus.gpr_rd), 32'd3); tick();
    set_in(1, 3, 'h33, 1, 10, 'hB, 9, 10); eval_chk();
    chkb("q2_prs", bus.pend_rs, 1'b1); tick();
    set_in(1, 3, 'h33, 0, 0, 0, 9, 10); eval_chk();
    chkb("q3_full", bus.b_ready, 1'b0);
    chkb("q3_prt", bus.pend_rt, 1'b1);
    chkv("q3_rd", 32'(bus.gpr_rd), 32'd3); tick();
    set_in(0, 0, 0, 0, 0, 0, 9, 10); eval_chk();
    chkv("dr1_rd", 32'(bus.gpr_rd), 32'd9);
    chkv("dr1_wd", bus.gpr_wd, 32'hA); tick();
    eval_chk();
    chkv("dr2_rd", 32'(bus.gpr_rd), 32'd10);
    chkv("dr2_wd", bus.gpr_wd, 32'hB); tick();
    eval_chk();
    chkb("dr3_we", bus.gpr_we, 1'b0); tick();

    // starvation: one queued B under continuous A
    set_in(1, 4, 'h44, 1, 12, 'hC, 12, 0); eval_chk(); tick();
    for (int i = 0; i < SL; i++) begin
      set_in(1, 4, 'h44, 0, 0, 0, 12, 0); eval_chk();
      chkb("stv_ardy", bus.a_ready, 1'b1);
      chkv("stv_rd", 32'(bus.gpr_rd), 32'd4);
      tick();
    end
    eval_chk();
    chkb("stv5_ardy", bus.a_ready, 1'b0);
    chkv("stv5_rd", 32'(bus.gpr_rd), 32'd12);
    chkv("stv5_wd", bus.gpr_wd, 32'hC); tick();
    eval_chk();
    chkb("stv6_ardy", bus.a_ready, 1'b1);
    chkv("stv6_rd", 32'(bus.gpr_rd), 32'd4); tick();

    // register zero
    set_in(1, 0, 'h55, 1, 0, 'h66, 0, 0); eval_chk();
    chkb("z_we", bus.gpr_we, 1'b0);
    chkb("z_ardy", bus.a_ready, 1'b1);
    chkb("z_brdy", bus.b_ready, 1'b1);
    chkb("z_prs", bus.pend_rs, 1'b0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); eval_chk();
    chkb("z2_we", bus.gpr_we, 1'b0); tick();

    // mid-run reset with two queued entries
    set_in(1, 5, 'h5, 1, 20, 'h14, 20, 21); eval_chk(); tick();
    set_in(1, 5, 'h5, 1, 21, 'h15, 20, 21); eval_chk(); tick();
    set_in(1, 5, 'h5, 0, 0, 0, 20, 21); eval_chk();
    chkb("mr_full", bus.b_ready, 1'b0);
    chkb("mr_prt", bus.pend_rt, 1'b1); tick();
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 20, 21); eval_chk();
    chkb("mr_rst_we", bus.gpr_we, 1'b0); tick();
    rst = 1;
    eval_chk();
    chkb("mr_we", bus.gpr_we, 1'b0);
    chkb("mr_prs", bus.pend_rs, 1'b0);
    chkb("mr_brdy", bus.b_ready, 1'b1); tick();
    eval_chk();
    chkb("mr2_we", bus.gpr_we, 1'b0); tick();

    // random traffic; stalled A and refused B hold their request
    for (int c = 0; c < 3000; c++) begin
      logic hold_a, hold_b;
      hold_a = bus.a_valid && !e_ar && m_rst;
      hold_b = bus.b_valid && !e_br && m_rst;
      rst = ($urandom_range(0, 149) != 0);
      if (!hold_a) begin
        bus.a_valid = ($urandom_range(0, 9) < 6);
        bus.a_rd    = 5'($urandom_range(0, 7));
        bus.a_wd    = $urandom;
      end
      if (!hold_b) begin
        bus.b_valid = ($urandom_range(0, 9) < 5);
        bus.b_rd    = 5'($urandom_range(0, 7));
        bus.b_wd    = $urandom;
      end
      bus.q_rs = 5'($urandom_range(0, 7));
      bus.q_rt = 5'($urandom_range(0, 7));
      eval_chk();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpr_wr_arbiter.md
# gpr_wr_arbiter

Write-port arbiter and pending-write scoreboard for the 32×32 general-purpose register file. It shares the file's single write port (`we`/`rd`/`wd`) between two requesters:
- the pipeline writeback stage (port A, priority)
- the multi-cycle multiply/divide unit (port B, buffered)

Buffered B results are tracked so the hazard unit can stall reads of registers whose write is still queued. It sits between the WB stage, the MD unit and `gpr`.

## Interface
- `DEPTH`, 2 — B-result FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 4 — consecutive A wins with B pending before A is stalled for one cycle (≥1)
- `AW`, 5 — register address width
- `DW`, 32 — data width

Ports:
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — synchronous, active-low reset (0 = reset)
- `a_valid` in 1 — WB stage has a write
- `a_rd` in AW — WB destination
- `a_wd` in DW — WB data
- `a_ready` out 1 — A write taken this cycle; 0 means WB must hold `a_*`
- `b_valid` in 1 — MD result available
- `b_rd` in AW — MD destination
- `b_wd` in DW — MD data
- `b_ready` out 1 — arbiter accepts B this cycle
- `q_rs`, `q_rt` in AW — hazard-unit read addresses
- `pend_rs`, `pend_rt` out 1 — queried register has a queued B write
- `gpr_we` out 1 — to `gpr.we`
- `gpr_rd` out AW — to `gpr.rd`
- `gpr_wd` out DW — to `gpr.wd`

## Operation
- **Effective requests:** a write to address 0 is never effective.
  - A with `a_rd==0`: accepted if `a_ready`, no write issued.
  - B with `b_rd==0`: accepted if `b_ready`, discarded, never queued.
- **`b_ready`:** `count < DEPTH`, from registered state only.
- **Stall:** `stall = (starve_cnt == STARVE_LIMIT)`; `a_ready = ~stall`.
- **Grant per cycle, in priority order:**
  1. `stall`: FIFO head written, popped; A not taken.
  2. Effective A: A written.
  3. FIFO non-empty: head written, popped.
  4. Effective B with FIFO empty: B written directly (bypass), not queued.
  5. Otherwise `gpr_we=0`.
- **Push:** accepted effective B is pushed unless bypassed in step 4. Push and pop in the same cycle is allowed, and `count` is unchanged.
- **`starve_cnt` (width ≥ clog2(STARVE_LIMIT+1)):**
  - +1 when an effective A wins while the FIFO is non-empty.
  - Cleared when the FIFO is empty or a FIFO pop occurs.
  - Never exceeds `STARVE_LIMIT`.
- **Scoreboard:** `pend_rs = (q_rs!=0)` AND any valid FIFO entry has `rd==q_rs`; same for `pend_rt`. Covers registered entries only; bypassed and in-flight B writes are not flagged.
- **Ordering:**
  - B results leave in arrival order.
  - If A and a queued B target the same register, the later grant wins. Software/hazard unit prevents this via `pend_*`.

## Timing
- **Grant path:** `gpr_*` and `a_ready` are combinational from current inputs and state; the `gpr` write lands on the same edge.
- **Latency:**
  - A: 0 cycles.
  - B bypass: 0 cycles.
  - Queued B: ≥1 cycle.
  - Worst case for a queued B head under continuous A traffic: `STARVE_LIMIT+1` cycles.
- **Reset (`rst==0` at an edge):**
  - FIFO emptied, `count=0`, `starve_cnt=0`.
  - Mid-operation, queued B results are lost.
  - While `rst==0`, outputs are forced: `gpr_we=0`, `gpr_rd=0`, `gpr_wd=0`, `a_ready=1`, `b_ready=0`, `pend_*=0`.
- **Full:** `count==DEPTH` → `b_ready=0` even if a pop occurs that cycle.
- **Wrap-around:** read/write pointers are `clog2(DEPTH)` bits and wrap naturally; `count` is `clog2(DEPTH)+1` bits.

## Structure
- **Shared package:** `GPR_AW=5`, `GPR_DW=32`, register-zero constant. The `gpr` module and this block both use it.
- **Sub-module:** `wr_fifo` — synchronous FIFO with push/pop/count and an entry-valid/address vector exposed for the scoreboard compare.
- **Arbiter body:** grant mux, starvation counter and scoreboard comparators.

## Test plan
- **Reset:** hold `rst=0` 3 cycles with `a_valid=b_valid=1` → `gpr_we=0`, `b_ready=0`, `a_ready=1`. Release → first cycle `count=0`.
- **Bypass:** A idle, `b_valid=1, b_rd=8, b_wd=0x1234` → same cycle `gpr_we=1, gpr_rd=8, gpr_wd=0x1234`, `pend_rs(q_rs=8)=0`.
- **Queue/scoreboard:**
  - A writes `$3` continuously while B sends `$9=0xA`, `$10=0xB` → both queued.
  - `pend_rs=1` for `q_rs=9`, `pend_rt=1` for `q_rt=10`.
  - `b_ready=0` at `count=2`.
  - Drained in order `$9` then `$10` once A idles.
- **Starvation** (`STARVE_LIMIT=4`): continuous effective A with one queued B →
  - A granted 4 cycles.
  - Cycle 5: `a_ready=0`, B head written.
  - Cycle 6: `a_ready=1`, A (held) written.
- **Register zero:** `a_rd=0` and `b_rd=0, b_valid=1` with FIFO empty → `gpr_we=0`, both accepted, `count` stays 0. `q_rs=0` → `pend_rs=0`.
- **Mid-run reset:** 2 entries queued, `rst=0` one cycle → FIFO empty, `pend_*=0`, queued writes never reach `gpr`.
